// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared types and width helpers for the instruction-cache refill controller.
//   state_t     : refill FSM states (IDLE, REQ, FILL, UPDATE)
//   *_DEF       : default widths used by the controller and its interface
//   calc_off_w  : word-offset width inside a line
//   calc_tag_w  : tag width left over after index, offset and byte bits
// -----------------------------------------------------------------------------
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      FILL   = 2'd2,
      UPDATE = 2'd3
   } state_t;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int WPL_DEF     = 4;
   localparam int INDEX_W_DEF = 6;

   function automatic int calc_off_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   // Two low address bits select a byte within a 32-bit word.
   function automatic int calc_tag_w(input int addr_w, input int index_w, input int off_w);
      return addr_w - index_w - off_w - 2;
   endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl_if
// Bundles the lookup-side miss handshake, the memory burst port and the
// data/tag array write ports of the refill controller.
//   master : refill controller side (drives busy, mem_req/addr, arr_*, tag_*,
//            fill_done; receives miss_*, mem_gnt, mem_rvalid, mem_rdata)
//   slave  : environment side (lookup logic, memory, arrays)
// -----------------------------------------------------------------------------
interface icache_refill_ctrl_if
   import icache_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int WORDS_PER_LINE = WPL_DEF,
   parameter int INDEX_W        = INDEX_W_DEF
) ();

   localparam int OFF_W = calc_off_w(WORDS_PER_LINE);
   localparam int TAG_W = calc_tag_w(ADDR_W, INDEX_W, OFF_W);

   logic               miss_req;
   logic [ADDR_W-1:0]  miss_addr;
   logic               busy;
   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_gnt;
   logic               mem_rvalid;
   logic [DATA_W-1:0]  mem_rdata;
   logic               arr_we;
   logic [INDEX_W-1:0] arr_index;
   logic [OFF_W-1:0]   arr_word;
   logic [DATA_W-1:0]  arr_wdata;
   logic               tag_we;
   logic [INDEX_W-1:0] tag_index;
   logic [TAG_W-1:0]   tag_value;
   logic               fill_done;

   modport master (
      input  miss_req, miss_addr, mem_gnt, mem_rvalid, mem_rdata,
      output busy, mem_req, mem_addr, arr_we, arr_index, arr_word, arr_wdata,
             tag_we, tag_index, tag_value, fill_done
   );

   modport slave (
      output miss_req, miss_addr, mem_gnt, mem_rvalid, mem_rdata,
      input  busy, mem_req, mem_addr, arr_we, arr_index, arr_word, arr_wdata,
             tag_we, tag_index, tag_value, fill_done
   );

endinterface

// File: rtl/refill_word_ctr.sv
// -----------------------------------------------------------------------------
// refill_word_ctr
// Word position counter for one line refill. Loaded with the first word
// offset of the burst, advanced on every accepted word, wrapping modulo the
// line size. o_last flags the word that completes the line.
//   clk, rst : clock, asynchronous active-high reset (counter to 0)
//   i_load   : load i_start (refill begins)
//   i_start  : first word offset of the burst
//   i_inc    : one word accepted this cycle
//   o_word   : word position of the current beat
//   o_last   : current beat is the final word of the line
// -----------------------------------------------------------------------------
module refill_word_ctr #(
   parameter int OFF_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [OFF_W-1:0] i_start,
   input  logic             i_inc,
   output logic [OFF_W-1:0] o_word,
   output logic             o_last
);

   logic [OFF_W-1:0] r_word;
   logic [OFF_W-1:0] r_first;
   logic [OFF_W-1:0] w_word_inc;

   assign w_word_inc = r_word + OFF_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word  <= '0;
         r_first <= '0;
      end else if (i_load) begin
         r_word  <= i_start;
         r_first <= i_start;
      end else if (i_inc) begin
         r_word  <= w_word_inc;
      end
   end

   // The line is complete when the next position would wrap back to the start.
   assign o_word = r_word;
   assign o_last = (w_word_inc == r_first);

endmodule

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
// Sequences an instruction-cache line refill: on a miss it issues one burst
// read, writes every returned word into the data array, then writes tag and
// valid for the line and pulses fill_done to release the core.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-high reset
//   bus   : icache_refill_ctrl_if.master (miss handshake, memory burst port,
//           data-array and tag-array write ports, busy, fill_done)
// Configuration macro:
//   ICACHE_CWF_EN : critical-word-first. Burst starts at the word-aligned miss
//                   address and the array is written from the missing word,
//                   wrapping around the line. Undefined: line-aligned burst,
//                   words written 0 .. WORDS_PER_LINE-1.
// -----------------------------------------------------------------------------
module icache_refill_ctrl
   import icache_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int WORDS_PER_LINE = WPL_DEF,
   parameter int INDEX_W        = INDEX_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   icache_refill_ctrl_if.master bus
);

   localparam int OFF_W = calc_off_w(WORDS_PER_LINE);
   localparam int TAG_W = calc_tag_w(ADDR_W, INDEX_W, OFF_W);

   state_t             r_state;
   state_t             w_next_state;
   logic [TAG_W-1:0]   r_tag;
   logic [INDEX_W-1:0] r_index;
   logic [OFF_W-1:0]   r_start;
   logic [OFF_W-1:0]   w_start;
   logic               w_leave_idle;
   logic               w_accept;
   logic [OFF_W-1:0]   w_word;
   logic               w_last;

`ifdef ICACHE_CWF_EN
   assign w_start = bus.miss_addr[OFF_W+1:2];
`else
   assign w_start = '0;
`endif

   assign w_leave_idle = (r_state == IDLE) && bus.miss_req;
   assign w_accept     = (r_state == FILL) && bus.mem_rvalid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Line address is captured once; the core holds miss_addr while busy, but
   // the registers make the refill independent of it.
   always_ff @(posedge clk) begin
      if (w_leave_idle) begin
         r_tag   <= bus.miss_addr[ADDR_W-1:OFF_W+INDEX_W+2];
         r_index <= bus.miss_addr[OFF_W+INDEX_W+1:OFF_W+2];
         r_start <= w_start;
      end
   end

   refill_word_ctr #(.OFF_W(OFF_W)) u_word_ctr (
      .clk     (clk),
      .rst     (reset),
      .i_load  (w_leave_idle),
      .i_start (w_start),
      .i_inc   (w_accept),
      .o_word  (w_word),
      .o_last  (w_last)
   );

   // All outputs decode from the state, so they are 0 the moment reset hits.
   always_comb begin
      w_next_state  = r_state;
      bus.busy      = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_addr  = '0;
      bus.arr_we    = 1'b0;
      bus.arr_index = '0;
      bus.arr_word  = '0;
      bus.arr_wdata = '0;
      bus.tag_we    = 1'b0;
      bus.tag_index = '0;
      bus.tag_value = '0;
      bus.fill_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.miss_req) w_next_state = REQ;
         end
         REQ: begin
            bus.busy     = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_addr = {r_tag, r_index, r_start, 2'b00};
            if (bus.mem_gnt) w_next_state = FILL;
         end
         FILL: begin
            bus.busy = 1'b1;
            if (bus.mem_rvalid) begin
               bus.arr_we    = 1'b1;
               bus.arr_index = r_index;
               bus.arr_word  = w_word;
               bus.arr_wdata = bus.mem_rdata;
               if (w_last) w_next_state = UPDATE;
            end
         end
         UPDATE: begin
            bus.busy      = 1'b1;
            bus.tag_we    = 1'b1;
            bus.tag_index = r_index;
            bus.tag_value = r_tag;
            bus.fill_done = 1'b1;
            w_next_state  = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_ctrl
// Scoreboard bench for icache_refill_ctrl (default parameters). Stimulus tasks
// push the expected burst address, array writes and tag write of every refill
// into queues; a monitor on the falling clock edge pops and compares whenever
// the controller raises mem_req, arr_we or tag_we/fill_done.
// -----------------------------------------------------------------------------
module tb_icache_refill_ctrl;
   import icache_pkg::*;

`ifdef ICACHE_CWF_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   typedef struct packed {
      logic [5:0]  idx;
      logic [1:0]  word;
      logic [31:0] data;
   } arr_t;

   typedef struct packed {
      logic [21:0] tag;
      logic [5:0]  idx;
   } tag_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   icache_refill_ctrl_if ifc ();

   icache_refill_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   int checks = 0;
   int errors = 0;

   arr_t        q_arr[$];
   tag_t        q_tag[$];
   logic [31:0] q_addr[$];

   arr_t        mon_arr;
   tag_t        mon_tag;
   logic [31:0] mon_addr;
   logic        prev_req = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Monitor: compares every DUT-presented event against the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         prev_req = 1'b0;
      end else begin
         if (ifc.arr_we) begin
            if (q_arr.size() == 0) check("arr_we_unexpected", 32'd1, 32'd0);
            else begin
               mon_arr = q_arr.pop_front();
               check("arr_index", 32'(ifc.arr_index), 32'(mon_arr.idx));
               check("arr_word",  32'(ifc.arr_word),  32'(mon_arr.word));
               check("arr_wdata", ifc.arr_wdata,      mon_arr.data);
            end
         end
         if (ifc.tag_we || ifc.fill_done) begin
            if (q_tag.size() == 0) check("tag_we_unexpected", 32'd1, 32'd0);
            else begin
               mon_tag = q_tag.pop_front();
               check("tag_we",    32'(ifc.tag_we),    32'd1);
               check("fill_done", 32'(ifc.fill_done), 32'd1);
               check("tag_value", 32'(ifc.tag_value), 32'(mon_tag.tag));
               check("tag_index", 32'(ifc.tag_index), 32'(mon_tag.idx));
            end
         end
         if (ifc.mem_req && !prev_req) begin
            if (q_addr.size() == 0) check("mem_req_unexpected", 32'd1, 32'd0);
            else begin
               mon_addr = q_addr.pop_front();
               check("mem_addr", ifc.mem_addr, mon_addr);
            end
         end
         prev_req = ifc.mem_req;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_arr(input logic [5:0] idx, input logic [1:0] word, input logic [31:0] data);
      arr_t e;
      e.idx  = idx;
      e.word = word;
      e.data = data;
      q_arr.push_back(e);
   endtask

   task automatic expect_line(input logic [31:0] maddr, input logic [5:0] idx, input logic [1:0] start,
                              input logic [21:0] tag, input logic [31:0] base);
      tag_t t;
      q_addr.push_back(maddr);
      for (int k = 0; k < 4; k++) expect_arr(idx, 2'(start + 2'(k)), base + 32'(k));
      t.tag = tag;
      t.idx = idx;
      q_tag.push_back(t);
   endtask

   task automatic issue_miss(input logic [31:0] a);
      ifc.miss_addr = a;
      ifc.miss_req  = 1'b1;
      step();
      ifc.miss_req  = 1'b0;
      check("busy_after_miss",    32'(ifc.busy),    32'd1);
      check("mem_req_after_miss", 32'(ifc.mem_req), 32'd1);
   endtask

   task automatic grant(input int delay);
      repeat (delay) step();
      ifc.mem_gnt = 1'b1;
      step();
      ifc.mem_gnt = 1'b0;
   endtask

   // pat is read MSB-first over its low n bits; one word per set bit.
   task automatic send(input logic [6:0] pat, input int n, input logic [31:0] base);
      int w;
      w = 0;
      for (int i = 0; i < n; i++) begin
         ifc.mem_rvalid = pat[n-1-i];
         ifc.mem_rdata  = pat[n-1-i] ? base + 32'(w) : 32'hDEAD_BEEF;
         if (pat[n-1-i]) w++;
         step();
      end
      ifc.mem_rvalid = 1'b0;
      ifc.mem_rdata  = '0;
   endtask

   task automatic finish_line();
      check("tag_we_in_update", 32'(ifc.tag_we), 32'd1);
      check("busy_in_update",   32'(ifc.busy),   32'd1);
      step();
      check("busy_after_update", 32'(ifc.busy),   32'd0);
      check("tag_we_after",      32'(ifc.tag_we), 32'd0);
   endtask

   task automatic check_all_zero(input string tag_s);
      check({tag_s, "_busy"},      32'(ifc.busy),      32'd0);
      check({tag_s, "_mem_req"},   32'(ifc.mem_req),   32'd0);
      check({tag_s, "_mem_addr"},  ifc.mem_addr,       32'd0);
      check({tag_s, "_arr_we"},    32'(ifc.arr_we),    32'd0);
      check({tag_s, "_tag_we"},    32'(ifc.tag_we),    32'd0);
      check({tag_s, "_fill_done"}, 32'(ifc.fill_done), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      ifc.miss_req   = 1'b0;
      ifc.miss_addr  = '0;
      ifc.mem_gnt    = 1'b0;
      ifc.mem_rvalid = 1'b0;
      ifc.mem_rdata  = '0;
      step();
      check_all_zero("reset");
      step();
      reset = 1'b0;
      step();

      // Basic refill: 0x1234 -> index 0x23, tag 0x4, offset 1.
      expect_line(CWF ? 32'h0000_1234 : 32'h0000_1230, 6'h23, CWF ? 2'd1 : 2'd0, 22'h4, 32'hA0);
      issue_miss(32'h0000_1234);
      grant(2);
      send(7'b0001111, 4, 32'hA0);
      finish_line();

      // Gapped data: 0x2048 -> index 0x04, tag 0x8, offset 2.
      expect_line(CWF ? 32'h0000_2048 : 32'h0000_2040, 6'h04, CWF ? 2'd2 : 2'd0, 22'h8, 32'hB0);
      issue_miss(32'h0000_2048);
      grant(0);
      send(7'b1001101, 7, 32'hB0);
      finish_line();

      // Spurious miss_req / mem_rvalid while waiting for grant.
      expect_line(32'h0000_3000, 6'h00, 2'd0, 22'hC, 32'hC0);
      issue_miss(32'h0000_3000);
      for (int i = 0; i < 3; i++) begin
         ifc.miss_req   = (i != 1);
         ifc.mem_rvalid = 1'b1;
         ifc.mem_rdata  = 32'hDEAD_0000 + 32'(i);
         #1;
         check("req_arr_we",  32'(ifc.arr_we),  32'd0);
         check("req_mem_req", 32'(ifc.mem_req), 32'd1);
         step();
      end
      ifc.miss_req   = 1'b0;
      ifc.mem_rvalid = 1'b0;
      grant(0);
      send(7'b0001111, 4, 32'hC0);
      finish_line();

      // Reset after two of four words: no tag write, then a clean refill.
      q_addr.push_back(32'h0000_1230);
      expect_arr(6'h23, 2'd0, 32'hD0);
      expect_arr(6'h23, 2'd1, 32'hD1);
      issue_miss(32'h0000_1230);
      grant(0);
      send(7'b0000011, 2, 32'hD0);
      ifc.mem_rvalid = 1'b1;
      ifc.mem_rdata  = 32'hD2;
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      ifc.mem_rvalid = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
      expect_line(32'h0000_1230, 6'h23, 2'd0, 22'h4, 32'hE0);
      issue_miss(32'h0000_1230);
      grant(1);
      send(7'b0001111, 4, 32'hE0);
      finish_line();

      // Back-to-back misses; second request rises right after IDLE.
      expect_line(32'h0000_0000, 6'h00, 2'd0, 22'h0, 32'h10);
      expect_line(32'h0000_0400, 6'h00, 2'd0, 22'h1, 32'h20);
      issue_miss(32'h0000_0000);
      grant(0);
      send(7'b0001111, 4, 32'h10);
      finish_line();
      issue_miss(32'h0000_0400);
      grant(0);
      send(7'b0001111, 4, 32'h20);
      finish_line();

      step();
      check("q_arr_empty",  32'(q_arr.size()),  32'd0);
      check("q_tag_empty",  32'(q_tag.size()),  32'd0);
      check("q_addr_empty", 32'(q_addr.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
